// File: rtl/axi_wr_stream_pkg.sv
// Shared definitions for the AXI-3 streaming write master.
// Holds the AXI response and burst-type codes, the status encodings reported
// to the command issuer, and the state type of the command sequencer.
package axi_wr_stream_pkg;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_EXOKAY = 2'b01;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;
  localparam logic [1:0] BRESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR = 2'b01;

  // Bursts may never cross a 4 KB page
  localparam int PAGE_BYTES = 4096;

  typedef enum logic [1:0] {
    STATUS_READY = 2'd0,
    STATUS_BUSY  = 2'd1,
    STATUS_OK    = 2'd2,
    STATUS_ERR   = 2'd3
  } status_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  // SLVERR and DECERR both count as a failed burst
  function automatic logic resp_is_error(input logic [1:0] resp);
    return resp >= BRESP_SLVERR;
  endfunction

endpackage

// File: rtl/axi_wr_len_fifo.sv
// Small synchronous FIFO holding the aw_len of every burst whose address
// has been accepted but whose data beats have not all been sent yet.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   push, data     : write an entry (ignored when full unless popping)
//   pop            : drop the head entry (ignored when empty)
//   full, empty    : occupancy flags
//   head           : oldest entry
module axi_wr_len_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  assign full    = (32'(count) == DEPTH);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data;
        wr_ptr      <= bump(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= bump(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_wr_stream.sv
// AXI-3 write master turning one command (start address, beat count) into a
// series of INCR bursts, split at MAX_BURST_LEN and at 4 KB pages, with data
// taken from a valid/ready stream.
// Ports:
//   clock, reset_n           : clock, asynchronous active-low reset
//   start, id, addr,
//   total_beats, cache, prot,
//   user, lock, status       : command interface and completion status
//   s_data/s_strb/s_valid/
//   s_ready                  : input data stream
//   aw_*, w_*, b_*           : AXI-3 write address, data and response channels
module axi_wr_stream
  import axi_wr_stream_pkg::*;
#(
  parameter int ID_WIDTH        = 8,
  parameter int ADDR_WIDTH      = 32,
  parameter int BUS_WIDTH       = 64,
  parameter int MAX_BURST_LEN   = 16,
  parameter int MAX_OUTSTANDING = 2,
  parameter int LEN_WIDTH       = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [ID_WIDTH-1:0]    id,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [LEN_WIDTH-1:0]   total_beats,
  input  logic [3:0]             cache,
  input  logic [2:0]             prot,
  input  logic [4:0]             user,
  input  logic [1:0]             lock,
  output logic [1:0]             status,
  input  logic [BUS_WIDTH-1:0]   s_data,
  input  logic [BUS_WIDTH/8-1:0] s_strb,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [ID_WIDTH-1:0]    aw_id,
  output logic [ADDR_WIDTH-1:0]  aw_addr,
  output logic [3:0]             aw_len,
  output logic [2:0]             aw_size,
  output logic [1:0]             aw_burst,
  output logic [1:0]             aw_lock,
  output logic [3:0]             aw_cache,
  output logic [2:0]             aw_prot,
  output logic [4:0]             aw_user,
  output logic                   aw_valid,
  input  logic                   aw_ready,
  output logic [ID_WIDTH-1:0]    w_id,
  output logic [BUS_WIDTH-1:0]   w_data,
  output logic [BUS_WIDTH/8-1:0] w_strb,
  output logic                   w_last,
  output logic                   w_valid,
  input  logic                   w_ready,
  input  logic [ID_WIDTH-1:0]    b_id,
  input  logic [1:0]             b_resp,
  input  logic                   b_valid,
  output logic                   b_ready
);

  localparam int AW_SIZE = $clog2(BUS_WIDTH / 8);
  localparam int OW      = $clog2(MAX_OUTSTANDING + 1);

  state_e                 state;
  state_e                 state_next;
  logic [LEN_WIDTH-1:0]   remaining;
  logic [LEN_WIDTH-1:0]   next_remaining;
  logic [ADDR_WIDTH-1:0]  next_addr;
  logic [OW-1:0]          outstanding;
  logic [OW-1:0]          outstanding_next;
  logic [3:0]             beat_cnt;
  logic [4:0]             cur_len;
  logic                   err_flag;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [3:0]             fifo_head;
  logic                   active;
  logic                   launch;
  logic                   done;
  logic                   aw_hs;
  logic                   w_hs;
  logic                   b_hs;
  logic                   unused_signals;

  // Beats in the next burst: limited by what is left, the burst cap and the
  // distance to the next 4 KB page
  function automatic logic [4:0] burst_len(input logic [11:0] offset,
                                           input logic [LEN_WIDTH-1:0] beats);
    logic [12:0] page_beats;
    logic [4:0]  len;
    page_beats = (13'(PAGE_BYTES) - {1'b0, offset}) >> AW_SIZE;
    len = 5'(MAX_BURST_LEN);
    if (32'(beats) < 32'(len)) len = 5'(beats);
    if (32'(page_beats) < 32'(len)) len = 5'(page_beats);
    return len;
  endfunction

  assign aw_size  = 3'(AW_SIZE);
  assign aw_burst = BURST_INCR;
  assign w_id     = aw_id;

  assign launch = (state == ST_IDLE) && start;
  assign aw_hs  = aw_valid && aw_ready;
  assign b_hs   = b_valid && b_ready;
  assign b_ready = (outstanding != '0);

  // Data path is purely combinational so the stream can run at one beat
  // per cycle while a burst is open
  assign active  = !fifo_empty;
  assign w_valid = s_valid && active;
  assign s_ready = w_ready && active;
  assign w_data  = s_data;
  assign w_strb  = s_strb;
  assign w_last  = active && (beat_cnt == fifo_head);
  assign w_hs    = w_valid && w_ready;

  assign cur_len        = {1'b0, aw_len} + 5'd1;
  assign next_addr      = aw_addr + (ADDR_WIDTH'(cur_len) << AW_SIZE);
  assign next_remaining = remaining - LEN_WIDTH'(cur_len);

  assign done = (remaining == '0) && (outstanding == '0) && fifo_empty && !aw_valid;

  assign unused_signals = ^{b_id, fifo_full};

  // Bursts in flight after this cycle; a simultaneous AW and B cancel out
  always_comb begin
    outstanding_next = outstanding;
    if (aw_hs && !b_hs) begin
      outstanding_next = outstanding + OW'(1);
    end else if (!aw_hs && b_hs) begin
      outstanding_next = outstanding - OW'(1);
    end
  end

  // Address channel: the next burst is precomputed on every handshake so
  // back-to-back bursts need no idle cycle, and the payload only changes
  // on a handshake
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      aw_valid  <= 1'b0;
      aw_addr   <= '0;
      aw_len    <= '0;
      aw_id     <= '0;
      aw_cache  <= '0;
      aw_prot   <= '0;
      aw_user   <= '0;
      aw_lock   <= '0;
      remaining <= '0;
    end else if (launch) begin
      aw_addr   <= addr;
      remaining <= total_beats;
      aw_len    <= 4'(burst_len(addr[11:0], total_beats) - 5'd1);
      aw_valid  <= (total_beats != '0);
      aw_id     <= id;
      aw_cache  <= cache;
      aw_prot   <= prot;
      aw_user   <= user;
      aw_lock   <= lock;
    end else if (aw_hs) begin
      aw_addr   <= next_addr;
      remaining <= next_remaining;
      aw_len    <= 4'(burst_len(next_addr[11:0], next_remaining) - 5'd1);
      aw_valid  <= (next_remaining != '0) && (32'(outstanding_next) < MAX_OUTSTANDING);
    end else if (!aw_valid && (state == ST_BUSY)) begin
      aw_valid  <= (remaining != '0) && (32'(outstanding_next) < MAX_OUTSTANDING);
    end
  end

  // Beat counter within the head burst, outstanding count and sticky error
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      beat_cnt    <= '0;
      outstanding <= '0;
      err_flag    <= 1'b0;
    end else begin
      outstanding <= outstanding_next;
      if (w_hs) begin
        beat_cnt <= w_last ? 4'd0 : beat_cnt + 4'd1;
      end
      if (state == ST_DONE) begin
        err_flag <= 1'b0;
      end else if (b_hs && resp_is_error(b_resp)) begin
        err_flag <= 1'b1;
      end
    end
  end

  axi_wr_len_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (4)
  ) u_len_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (aw_hs),
    .data    (aw_len),
    .pop     (w_hs && w_last),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

  // Command sequencer state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and status; the done states last exactly one cycle
  always_comb begin
    state_next = state;
    status     = STATUS_READY;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_BUSY;
      end
      ST_BUSY: begin
        status = STATUS_BUSY;
        if (done) state_next = ST_DONE;
      end
      ST_DONE: begin
        status     = err_flag ? STATUS_ERR : STATUS_OK;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_wr_stream.sv
// Randomised scoreboard bench for axi_wr_stream: a reference model splits
// each command into bursts, a producer and slave drive the DUT, and a
// monitor compares every AW and W handshake against the expected queues.
module tb_axi_wr_stream;
  import axi_wr_stream_pkg::*;

  localparam int IDW   = 8;
  localparam int ADW   = 32;
  localparam int BW    = 64;
  localparam int MAXB  = 16;
  localparam int MAXO  = 2;
  localparam int LW    = 16;
  localparam int BYTES = BW / 8;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  len;
  } aw_exp_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } w_exp_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
  } beat_t;

  logic           clock;
  logic           reset_n;
  logic           start;
  logic [IDW-1:0] id;
  logic [ADW-1:0] addr;
  logic [LW-1:0]  total_beats;
  logic [3:0]     cache;
  logic [2:0]     prot;
  logic [4:0]     user;
  logic [1:0]     lock;
  logic [1:0]     status;
  logic [BW-1:0]  s_data;
  logic [7:0]     s_strb;
  logic           s_valid;
  logic           s_ready;
  logic [IDW-1:0] aw_id;
  logic [ADW-1:0] aw_addr;
  logic [3:0]     aw_len;
  logic [2:0]     aw_size;
  logic [1:0]     aw_burst;
  logic [1:0]     aw_lock;
  logic [3:0]     aw_cache;
  logic [2:0]     aw_prot;
  logic [4:0]     aw_user;
  logic           aw_valid;
  logic           aw_ready;
  logic [IDW-1:0] w_id;
  logic [BW-1:0]  w_data;
  logic [7:0]     w_strb;
  logic           w_last;
  logic           w_valid;
  logic           w_ready;
  logic [IDW-1:0] b_id;
  logic [1:0]     b_resp;
  logic           b_valid;
  logic           b_ready;

  aw_exp_t    exp_aw[$];
  w_exp_t     exp_w[$];
  beat_t      stream_q[$];
  logic [1:0] resp_q[$];

  int compared;
  int mismatched;
  int aw_seen;
  int out_cnt;
  bit rand_mode;
  bit b_hold;

  logic [IDW-1:0] cur_id;
  logic [3:0]     cur_cache;
  logic [2:0]     cur_prot;
  logic [4:0]     cur_user;
  logic [1:0]     cur_lock;

  axi_wr_stream #(
    .ID_WIDTH        (IDW),
    .ADDR_WIDTH      (ADW),
    .BUS_WIDTH       (BW),
    .MAX_BURST_LEN   (MAXB),
    .MAX_OUTSTANDING (MAXO),
    .LEN_WIDTH       (LW)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .id          (id),
    .addr        (addr),
    .total_beats (total_beats),
    .cache       (cache),
    .prot        (prot),
    .user        (user),
    .lock        (lock),
    .status      (status),
    .s_data      (s_data),
    .s_strb      (s_strb),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .aw_id       (aw_id),
    .aw_addr     (aw_addr),
    .aw_len      (aw_len),
    .aw_size     (aw_size),
    .aw_burst    (aw_burst),
    .aw_lock     (aw_lock),
    .aw_cache    (aw_cache),
    .aw_prot     (aw_prot),
    .aw_user     (aw_user),
    .aw_valid    (aw_valid),
    .aw_ready    (aw_ready),
    .w_id        (w_id),
    .w_data      (w_data),
    .w_strb      (w_strb),
    .w_last      (w_last),
    .w_valid     (w_valid),
    .w_ready     (w_ready),
    .b_id        (b_id),
    .b_resp      (b_resp),
    .b_valid     (b_valid),
    .b_ready     (b_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void check_output(string name, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Stream producer: presents queued beats, optionally with stalls
  initial begin : producer
    bit s_taken;
    s_taken = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_strb  = '0;
    forever begin
      @(negedge clock);
      if (s_taken && stream_q.size() > 0) void'(stream_q.pop_front());
      if (reset_n && stream_q.size() > 0 && (!rand_mode || $urandom_range(0, 2) != 0)) begin
        s_valid = 1'b1;
        s_data  = stream_q[0].data;
        s_strb  = stream_q[0].strb;
      end else begin
        s_valid = 1'b0;
        s_data  = {$urandom, $urandom};
        s_strb  = 8'($urandom);
      end
      #3;
      s_taken = s_valid && s_ready;
    end
  end

  // Slave: random readies, one B per completed W burst, responses from resp_q
  initial begin : slave
    int  b_pending;
    bit  b_taken;
    b_pending = 0;
    b_taken   = 1'b0;
    aw_ready  = 1'b0;
    w_ready   = 1'b0;
    b_valid   = 1'b0;
    b_resp    = BRESP_OKAY;
    b_id      = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        b_valid   = 1'b0;
        b_pending = 0;
        b_taken   = 1'b0;
        aw_ready  = 1'b0;
        w_ready   = 1'b0;
      end else begin
        if (b_taken) begin
          b_valid = 1'b0;
          b_pending--;
        end
        aw_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        w_ready  = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (!b_valid && b_pending > 0 && !b_hold && (!rand_mode || $urandom_range(0, 1) == 1)) begin
          b_valid = 1'b1;
          b_id    = cur_id;
          b_resp  = (resp_q.size() > 0) ? resp_q.pop_front() : BRESP_OKAY;
        end
        #3;
        b_taken = b_valid && b_ready;
        if (w_valid && w_ready && w_last) b_pending++;
      end
    end
  end

  // Monitor: compares every handshake against the scoreboard queues
  initial begin : monitor
    aw_exp_t ea;
    w_exp_t  ew;
    bit      aw_hs;
    bit      b_hs;
    out_cnt = 0;
    forever begin
      @(negedge clock);
      #2;
      if (!reset_n) begin
        out_cnt = 0;
      end else begin
        aw_hs = aw_valid && aw_ready;
        b_hs  = b_valid && b_ready;
        if (aw_hs) begin
          aw_seen++;
          check_output("aw_outstanding_limit", 64'(out_cnt < MAXO), 1);
          if (exp_aw.size() == 0) begin
            check_output("aw_unexpected", 1, 0);
          end else begin
            ea = exp_aw.pop_front();
            check_output("aw_addr", aw_addr, ea.addr);
            check_output("aw_len", aw_len, ea.len);
            check_output("aw_size", aw_size, 3);
            check_output("aw_burst", aw_burst, BURST_INCR);
            check_output("aw_id", aw_id, cur_id);
            check_output("aw_attrs", {aw_cache, aw_prot, aw_user, aw_lock},
                         {cur_cache, cur_prot, cur_user, cur_lock});
          end
        end
        if (w_valid && w_ready) begin
          if (exp_w.size() == 0) begin
            check_output("w_unexpected", 1, 0);
          end else begin
            ew = exp_w.pop_front();
            check_output("w_data", w_data, ew.data);
            check_output("w_strb", w_strb, ew.strb);
            check_output("w_last", w_last, ew.last);
            check_output("w_id", w_id, cur_id);
          end
        end
        if (aw_hs && !b_hs) out_cnt++;
        else if (!aw_hs && b_hs) out_cnt--;
      end
    end
  end

  // Splits a command into bursts with plain arithmetic, fills the stream
  // and expected queues, then runs the command to completion
  task automatic apply_stimulus(input int unsigned a, input int beats,
                                input int err_idx, input int hold);
    int unsigned addr_m;
    int          rem;
    int          len;
    int          page_left;
    int          nb;
    int          exp_status;
    int          c;
    beat_t       bt;
    addr_m = a;
    rem    = beats;
    nb     = 0;
    while (rem > 0) begin
      page_left = (4096 - (addr_m % 4096)) / BYTES;
      len = rem;
      if (len > MAXB) len = MAXB;
      if (len > page_left) len = page_left;
      exp_aw.push_back('{addr: addr_m, len: 4'(len - 1)});
      for (int i = 0; i < len; i++) begin
        bt.data = {$urandom, $urandom};
        bt.strb = 8'($urandom_range(1, 255));
        stream_q.push_back(bt);
        exp_w.push_back('{data: bt.data, strb: bt.strb, last: (i == len - 1)});
      end
      resp_q.push_back((nb == err_idx) ? (rand_mode ? BRESP_DECERR : BRESP_SLVERR) : BRESP_OKAY);
      addr_m += len * BYTES;
      rem    -= len;
      nb++;
    end
    exp_status = (err_idx >= 0 && err_idx < nb) ? 3 : 2;
    cur_id    = 8'($urandom);
    cur_cache = 4'($urandom);
    cur_prot  = 3'($urandom);
    cur_user  = 5'($urandom);
    cur_lock  = 2'($urandom);
    aw_seen   = 0;
    b_hold    = (hold > 0);
    @(negedge clock);
    start       = 1'b1;
    id          = cur_id;
    addr        = a;
    total_beats = LW'(beats);
    cache       = cur_cache;
    prot        = cur_prot;
    user        = cur_user;
    lock        = cur_lock;
    @(negedge clock);
    start = 1'b0;
    #1;
    check_output("status_busy", status, 1);
    check_output("aw_valid_launch", aw_valid, 64'(beats != 0));
    if (hold > 0) begin
      repeat (hold) @(negedge clock);
      #1;
      check_output("aw_count_held", aw_seen, MAXO);
      check_output("aw_valid_held", aw_valid, 0);
      b_hold = 1'b0;
    end
    c = 0;
    while (status == 2'd1 && c < 5000) begin
      @(negedge clock);
      #1;
      c++;
    end
    if (status == 2'd1) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL cmd_timeout: status still 1 after %0d cycles, expected completion", c);
    end else begin
      check_output("status_done", status, exp_status);
      check_output("aw_count", aw_seen, nb);
      check_output("w_beats_left", exp_w.size(), 0);
      check_output("outstanding_end", out_cnt, 0);
      if (beats == 0) check_output("zero_beat_latency", c, 1);
      @(negedge clock);
      #1;
      check_output("status_ready", status, 0);
    end
  endtask

  initial begin : main
    int unsigned ra;
    reset_n     = 1'b0;
    start       = 1'b0;
    id          = '0;
    addr        = '0;
    total_beats = '0;
    cache       = '0;
    prot        = '0;
    user        = '0;
    lock        = '0;
    rand_mode   = 1'b0;
    b_hold      = 1'b0;
    compared    = 0;
    mismatched  = 0;
    aw_seen     = 0;
    cur_id      = '0;
    cur_cache   = '0;
    cur_prot    = '0;
    cur_user    = '0;
    cur_lock    = '0;
    #3;
    check_output("reset_status", status, 0);
    check_output("reset_aw_valid", aw_valid, 0);
    check_output("reset_w_valid", w_valid, 0);
    check_output("reset_w_last", w_last, 0);
    check_output("reset_b_ready", b_ready, 0);
    check_output("reset_s_ready", s_ready, 0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    $display("[TB] directed commands");
    apply_stimulus(32'h0000_1000, 1, -1, 0);
    apply_stimulus(32'h0000_0000, 40, -1, 0);
    apply_stimulus(32'h0000_0FF0, 8, -1, 0);
    apply_stimulus(32'h0000_0000, 48, -1, 40);
    apply_stimulus(32'h0000_0000, 40, 1, 0);
    apply_stimulus(32'h0000_2000, 5, -1, 0);
    apply_stimulus(32'h0000_3000, 0, -1, 0);

    $display("[TB] random commands with stalls");
    rand_mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 1) == 1)
        ra = ($urandom_range(0, 7) << 12) | (4096 - 8 * $urandom_range(1, 20));
      else
        ra = ($urandom_range(0, 7) << 12) | ($urandom_range(0, 511) << 3);
      apply_stimulus(ra, $urandom_range(1, 70),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1, 0);
    end

    $display("[TB] reset in the middle of a command");
    fork
      apply_stimulus(32'h0000_4000, 64, -1, 0);
    join_none
    repeat (14) @(negedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    disable fork;
    check_output("midreset_aw_valid", aw_valid, 0);
    check_output("midreset_w_valid", w_valid, 0);
    check_output("midreset_status", status, 0);
    check_output("midreset_b_ready", b_ready, 0);
    exp_aw.delete();
    exp_w.delete();
    stream_q.delete();
    resp_q.delete();
    start = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    check_output("post_reset_status", status, 0);
    check_output("post_reset_aw_valid", aw_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
